// File: rtl/usart_rx_if.sv
// usart_rx_if: receiver-side byte handshake and status; rx_parity_error exists only with USART_RX_PARITY_EN
interface usart_rx_if;
    logic rx_pin;
    logic rx_ack;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_frame_error;
    logic rx_overrun;
`ifdef USART_RX_PARITY_EN
    logic rx_parity_error;
`endif
    modport slave (
        input rx_pin, rx_ack,
`ifdef USART_RX_PARITY_EN
        output rx_parity_error,
`endif
        output rx_data, rx_valid, rx_frame_error, rx_overrun
    );
    modport master (
        output rx_pin, rx_ack,
`ifdef USART_RX_PARITY_EN
        input rx_parity_error,
`endif
        input rx_data, rx_valid, rx_frame_error, rx_overrun
    );
endinterface

// File: rtl/usart_rx.sv
// usart_rx: oversampled 8-bit async receiver with sticky error flags; even parity bit enabled by USART_RX_PARITY_EN
module usart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input logic serial_clock,
    input logic reset,
    usart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
`ifdef USART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_n;
    logic [1:0] sync;
    logic line, tick, half, done, stop_bit, par_ok;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    assign line = sync[1];
    assign tick = cnt == CW'(OVERSAMPLE - 1);
    assign half = cnt == CW'(OVERSAMPLE / 2 - 1);
`ifdef USART_RX_PARITY_EN
    logic par_bit;
    assign par_ok = ~(^shift ^ par_bit);
`else
    assign par_ok = 1'b1;
`endif
    always_ff @(posedge serial_clock)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = line ? IDLE : START;
            START:   state_n = half ? (line ? IDLE : DATA) : START;
            DATA:    state_n = (tick && bit_cnt == 3'd7) ? AFTER_DATA : DATA;
`ifdef USART_RX_PARITY_EN
            PARITY:  state_n = tick ? STOP : PARITY;
`endif
            STOP:    state_n = done ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    // done marks the tick after the stop sample, when the frame is committed
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            sync <= 2'b11;
            cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
            done <= 1'b0;
            stop_bit <= 1'b1;
`ifdef USART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            sync <= {sync[0], bus.rx_pin};
            cnt <= (state_n != state || tick) ? '0 : cnt + 1'b1;
            bit_cnt <= state == DATA ? bit_cnt + 3'(tick) : '0;
            shift <= (state == DATA && tick) ? {line, shift[7:1]} : shift;
            done <= state == STOP && tick;
            stop_bit <= (state == STOP && tick) ? line : stop_bit;
`ifdef USART_RX_PARITY_EN
            par_bit <= (state == PARITY && tick) ? line : par_bit;
`endif
        end
    end
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_frame_error <= 1'b0;
            bus.rx_overrun <= 1'b0;
`ifdef USART_RX_PARITY_EN
            bus.rx_parity_error <= 1'b0;
`endif
        end else begin
            if (bus.rx_ack) begin
                bus.rx_valid <= 1'b0;
                bus.rx_frame_error <= 1'b0;
                bus.rx_overrun <= 1'b0;
`ifdef USART_RX_PARITY_EN
                bus.rx_parity_error <= 1'b0;
`endif
            end
            if (done) begin
                if (!stop_bit) bus.rx_frame_error <= 1'b1;
`ifdef USART_RX_PARITY_EN
                if (!par_ok) bus.rx_parity_error <= 1'b1;
`endif
                if (stop_bit && par_ok) begin
                    if (!bus.rx_valid || bus.rx_ack) begin
                        bus.rx_data <= shift;
                        bus.rx_valid <= 1'b1;
                    end else begin
                        bus.rx_overrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed frames against hand-computed receiver status (valid, frame_error, overrun, data)
module tb_usart_rx;
    localparam int OS = 16;
    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_err = 0;
    usart_rx_if bus ();
    usart_rx #(.OVERSAMPLE(OS)) dut (.serial_clock(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [10:0] stat;
    assign stat = {bus.rx_valid, bus.rx_frame_error, bus.rx_overrun, bus.rx_data};
`ifdef USART_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif
    // Starts and ends on a falling edge; rx_valid rises on the 12th clock of the stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack, input logic lat);
        bus.rx_pin = 1'b0;
        repeat (OS) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            bus.rx_pin = d[b];
            repeat (OS) @(negedge clk);
        end
`ifdef USART_RX_PARITY_EN
        bus.rx_pin = ^d ^ bad_par;
        repeat (OS) @(negedge clk);
`endif
        bus.rx_pin = stop;
        for (int i = 0; i < OS; i++) begin
            if (lat && i == 11) begin
                n_cmp++;
                if (bus.rx_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_early: rx_valid got %b want 0", bus.rx_valid);
                end
            end
            if (lat && i == 12) begin
                n_cmp++;
                if (bus.rx_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL latency_on_time: rx_valid got %b want 1", bus.rx_valid);
                end
            end
            bus.rx_ack = ack && i == 11;
            @(negedge clk);
        end
        bus.rx_ack = 1'b0;
        bus.rx_pin = 1'b1;
    endtask
    task automatic pulse_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (stat !== 11'h000) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", stat, 11'h000);
        end
`ifdef USART_RX_PARITY_EN
        n_cmp++;
        if (bus.rx_parity_error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_parity: got %b want 0", bus.rx_parity_error);
        end
`endif
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask
    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (stat !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_rx: got %h want %h", stat, {1'b1, 1'b0, 1'b0, 8'hA5});
        end
        pulse_ack();
        n_cmp++;
        if (stat !== {1'b0, 1'b0, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_ack: got %h want %h", stat, {1'b0, 1'b0, 1'b0, 8'hA5});
        end
    endtask
    task automatic test_glitch();
        bus.rx_pin = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx_pin = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (stat !== {1'b0, 1'b0, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL glitch: got %h want %h", stat, {1'b0, 1'b0, 1'b0, 8'hA5});
        end
    endtask
    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (stat !== {1'b0, 1'b1, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL frame_error: got %h want %h", stat, {1'b0, 1'b1, 1'b0, 8'hA5});
        end
        pulse_ack();
        n_cmp++;
        if (stat !== {1'b0, 1'b0, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL frame_error_ack: got %h want %h", stat, {1'b0, 1'b0, 1'b0, 8'hA5});
        end
    endtask
    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (stat !== {1'b1, 1'b0, 1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL overrun: got %h want %h", stat, {1'b1, 1'b0, 1'b1, 8'h11});
        end
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (stat !== {1'b1, 1'b0, 1'b0, 8'h22}) begin
            n_err++;
            $display("FAIL ack_on_completion: got %h want %h", stat, {1'b1, 1'b0, 1'b0, 8'h22});
        end
        pulse_ack();
        n_cmp++;
        if (stat !== {1'b0, 1'b0, 1'b0, 8'h22}) begin
            n_err++;
            $display("FAIL overrun_ack: got %h want %h", stat, {1'b0, 1'b0, 1'b0, 8'h22});
        end
    endtask
    task automatic test_reset_mid();
        bus.rx_pin = 1'b0;
        repeat (OS) @(negedge clk);
        bus.rx_pin = 1'b1;
        repeat (4 * OS + OS / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (stat !== 11'h000) begin
            n_err++;
            $display("FAIL reset_mid: got %h want %h", stat, 11'h000);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (stat !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin
            n_err++;
            $display("FAIL after_reset_rx: got %h want %h", stat, {1'b1, 1'b0, 1'b0, 8'h5A});
        end
        pulse_ack();
    endtask
    task automatic test_break();
        bus.rx_pin = 1'b0;
        repeat (312) @(negedge clk);
        bus.rx_pin = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (stat !== {1'b0, 1'b1, 1'b0, 8'h5A}) begin
            n_err++;
            $display("FAIL break: got %h want %h", stat, {1'b0, 1'b1, 1'b0, 8'h5A});
        end
        pulse_ack();
        n_cmp++;
        if (stat !== {1'b0, 1'b0, 1'b0, 8'h5A}) begin
            n_err++;
            $display("FAIL break_ack: got %h want %h", stat, {1'b0, 1'b0, 1'b0, 8'h5A});
        end
    endtask
`ifdef USART_RX_PARITY_EN
    task automatic test_parity();
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        bad_par = 1'b0;
        n_cmp++;
        if ({bus.rx_parity_error, stat} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h5A}) begin
            n_err++;
            $display("FAIL parity_bad: got %h want %h", {bus.rx_parity_error, stat}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h5A});
        end
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.rx_parity_error, stat} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h07}) begin
            n_err++;
            $display("FAIL parity_good: got %h want %h", {bus.rx_parity_error, stat}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h07});
        end
        pulse_ack();
    endtask
`endif
    initial begin
        bus.rx_pin = 1'b1;
        bus.rx_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid();
        test_break();
`ifdef USART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usart_rx.md
USART_RX -- requirements
Module: usart_rx

Interface
REQ-001 OVERSAMPLE, default 16: serial_clock ticks per bit period; even, range 4..64.
REQ-002 serial_clock  input  1  oversample clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 rx_pin  input  1  asynchronous serial line; idle high; frame is 1 start (0), 8 data LSB first, 1 stop (1).
REQ-005 rx_ack  input  1  consumer pulse: received byte taken.
REQ-006 rx_data  output  8  last accepted byte; stable while rx_valid=1.
REQ-007 rx_valid  output  1  byte available; held until rx_ack.
REQ-008 rx_frame_error  output  1  sticky: stop bit sampled 0.
REQ-009 rx_overrun  output  1  sticky: frame completed while rx_valid=1.
REQ-010 rx_parity_error  output  1  sticky parity mismatch; present only with USART_RX_PARITY_EN.

Function
REQ-011 rx_pin SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-tick input latency).
REQ-012 FSM states IDLE, START, DATA, STOP (PARITY inserted before STOP with macro); tick counter width ceil(log2(OVERSAMPLE)).
REQ-013 IDLE: synchronized line 0 -> START, counter cleared.
REQ-014 START: at tick OVERSAMPLE/2-1 sample line; 0 -> DATA, counter cleared; 1 -> glitch, back to IDLE, no flags change.
REQ-015 DATA: sample every OVERSAMPLE ticks (mid-bit); shift into bit 7 of shift register, right shift; after 8th sample -> STOP.
REQ-016 STOP: sample after OVERSAMPLE ticks; then return to IDLE on the next tick regardless of sampled value.
REQ-017 Stop sample 1, rx_valid=0: rx_data <= shift register, rx_valid <= 1 on the tick after the stop sample.
REQ-018 Stop sample 0: byte discarded, rx_frame_error <= 1, rx_valid unchanged.
REQ-019 Stop sample 1, rx_valid=1, no rx_ack same tick: new byte discarded, rx_data unchanged, rx_overrun <= 1.
REQ-020 rx_ack with rx_valid=1: rx_valid <= 0, rx_frame_error, rx_overrun, rx_parity_error <= 0 next tick.
REQ-021 rx_ack coincident with completion of a good frame: new byte loaded, rx_valid stays 1, flags cleared, no overrun.
REQ-022 rx_ack with rx_valid=0: no effect beyond clearing sticky flags.
REQ-023 Line held low continuously: after a frame error, next start is detected only via REQ-013; a break re-triggers frames, each raising rx_frame_error.
REQ-024 Frame length from start edge to rx_valid: (9.5*OVERSAMPLE)+1 ticks plus synchronizer latency.

Reset
REQ-025 reset SHALL force IDLE, counter 0, shift register 0, synchronizer flops 1, rx_data 0, rx_valid 0, all error flags 0.
REQ-026 reset mid-frame SHALL abandon the frame with no output; reception restarts on next start bit after reset deasserts.

Configuration
REQ-027 USART_RX_PARITY_EN defined: one even-parity bit between data and stop, sampled OVERSAMPLE ticks after bit 7; mismatch sets rx_parity_error and discards byte; stop checked as usual.
REQ-028 USART_RX_PARITY_EN undefined: no parity state, no rx_parity_error port, frame is 10 bits.

Verification
REQ-029 OVERSAMPLE=16, send 0xA5 8N1 -> rx_data=0xA5, rx_valid=1, no flags; rx_ack -> rx_valid=0 next tick.
REQ-030 Low glitch of 4 ticks on idle line -> FSM returns IDLE, rx_valid stays 0, no flags.
REQ-031 Send 0x3C with stop bit 0 -> rx_frame_error=1, rx_valid=0, rx_data unchanged.
REQ-032 Send 0x11 then 0x22 without ack -> rx_data=0x11, rx_overrun=1; repeat with rx_ack on 0x22 completion tick -> rx_data=0x22, rx_overrun=0.
REQ-033 Assert reset during data bit 4 of 0xFF -> all outputs 0; following 0x5A received correctly.
REQ-034 Macro on, send 0x07 with parity 0 -> rx_parity_error=1, rx_valid=0; parity 1 -> rx_data=0x07, rx_valid=1.
